// File: rtl/spi_telemetry_slave.sv
// SPI mode-0 slave exposing an auto-incrementing byte map: coherent telemetry snapshots on
// read, and a control bank that is committed atomically when a write frame ends cleanly.
module spi_telemetry_slave #(
  parameter int unsigned NUM_CHANNELS = 16,
  parameter int unsigned WORD_BYTES   = 4,
  parameter int unsigned NUM_CTRL     = 4,
  parameter logic [7:0]  STATUS_ID    = 8'hA5
) (
  input  logic                                 SPI_TELEM_CLOCK_50,
  input  logic                                 SPI_TELEM_RESET_InLow,
  input  logic                                 SPI_TELEM_SS_InLow,
  input  logic                                 SPI_TELEM_SCK_In,
  input  logic                                 SPI_TELEM_MOSI_In,
  input  logic [NUM_CHANNELS*WORD_BYTES*8-1:0] SPI_TELEM_CHAN_InBus,
  output logic                                 SPI_TELEM_MISO_Out,
  output logic [NUM_CTRL*8-1:0]                SPI_TELEM_CTRL_OutBus,
  output logic                                 SPI_TELEM_CTRLUPDATE_Out,
  output logic                                 SPI_TELEM_FRAMEERR_Out,
  output logic                                 SPI_TELEM_BUSY_Out
);

  localparam int unsigned MapBytes = NUM_CHANNELS * WORD_BYTES;
  localparam int unsigned ChanBits = MapBytes * 8;

  typedef enum logic [2:0] {StIdle, StCmd, StRd, StWr, StEnd} state_e;

  state_e                state_q, state_d;
  logic [2:0]            ss_q, sck_q;
  logic [1:0]            mosi_q;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [6:0]            rx_q, rx_d;
  logic [7:0]            tx_q, tx_d;
  logic                  miso_q, miso_d;
  logic [7:0]            addr_q, addr_d;
  logic                  oob_q, oob_d;
  logic                  err_q, err_d;
  logic                  seen_q, seen_d;
  logic [ChanBits-1:0]   shadow_q, shadow_d;
  logic [NUM_CTRL*8-1:0] pend_q, pend_d;
  logic [NUM_CTRL*8-1:0] ctrl_q, ctrl_d;
  logic                  upd_q, upd_d;
  logic                  ferr_q, ferr_d;

  logic       ss, ss_rise, sck_rise, sck_fall, byte_done;
  logic [7:0] rx_byte, next_addr;

  // Byte index b = k*WORD_BYTES + j maps to channel k, byte j counted from the MSByte.
  function automatic logic [7:0] byte_of(input logic [ChanBits-1:0] bus, input logic [7:0] idx);
    int unsigned b, j;
    b = 32'(idx);
    j = b % WORD_BYTES;
    return bus[(b - j + WORD_BYTES - 1 - j) * 8 +: 8];
  endfunction

  assign ss        = ss_q[1];
  assign ss_rise   = ss_q[1] & ~ss_q[2];
  assign sck_rise  = sck_q[1] & ~sck_q[2];
  assign sck_fall  = ~sck_q[1] & sck_q[2];
  assign rx_byte   = {rx_q, mosi_q[1]};
  assign byte_done = sck_rise && (bit_cnt_q == 3'd7);
  assign next_addr = (addr_q == 8'(MapBytes - 1)) ? 8'd0 : addr_q + 8'd1;

  always_ff @(posedge SPI_TELEM_CLOCK_50 or negedge SPI_TELEM_RESET_InLow) begin
    if (!SPI_TELEM_RESET_InLow) begin
      ss_q      <= 3'b111;
      sck_q     <= 3'b000;
      mosi_q    <= 2'b00;
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      miso_q    <= 1'b0;
      addr_q    <= '0;
      oob_q     <= 1'b0;
      err_q     <= 1'b0;
      seen_q    <= 1'b0;
      shadow_q  <= '0;
      pend_q    <= '0;
      ctrl_q    <= '0;
      upd_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      ss_q      <= {ss_q[1:0], SPI_TELEM_SS_InLow};
      sck_q     <= {sck_q[1:0], SPI_TELEM_SCK_In};
      mosi_q    <= {mosi_q[0], SPI_TELEM_MOSI_In};
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      miso_q    <= miso_d;
      addr_q    <= addr_d;
      oob_q     <= oob_d;
      err_q     <= err_d;
      seen_q    <= seen_d;
      shadow_q  <= shadow_d;
      pend_q    <= pend_d;
      ctrl_q    <= ctrl_d;
      upd_q     <= upd_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    miso_d    = miso_q;
    addr_d    = addr_q;
    oob_d     = oob_q;
    err_d     = err_q;
    seen_d    = seen_q;
    shadow_d  = shadow_q;
    pend_d    = pend_q;
    ctrl_d    = ctrl_q;
    upd_d     = 1'b0;
    ferr_d    = ferr_q;

    unique case (state_q)
      StIdle: begin
        // Level-triggered so a select that fell during END still opens a frame.
        if (!ss) begin
          state_d   = StCmd;
          bit_cnt_d = '0;
          tx_d      = STATUS_ID;
          miso_d    = STATUS_ID[7];
          pend_d    = ctrl_q;
          err_d     = 1'b0;
          seen_d    = 1'b0;
          oob_d     = 1'b0;
        end
      end
      StCmd, StRd, StWr: begin
        if (ss_rise) begin
          state_d = StEnd;
          if (state_q == StWr) begin
            if (bit_cnt_q != 3'd0) begin
              ferr_d = 1'b1;
            end else begin
              ferr_d = err_q;
              if (seen_q) begin
                ctrl_d = pend_q;
                upd_d  = 1'b1;
              end
            end
          end else if (state_q == StRd) begin
            ferr_d = err_q;
          end else begin
            ferr_d = 1'b0;
          end
        end else begin
          if (sck_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            rx_d      = rx_byte[6:0];
            tx_d      = {tx_q[6:0], 1'b0};
          end
          if (sck_fall) begin
            miso_d = tx_q[7];
          end
          if (byte_done) begin
            if (state_q == StCmd) begin
              addr_d = {1'b0, rx_byte[6:0]};
              if (rx_byte[7]) begin
                state_d  = StRd;
                shadow_d = SPI_TELEM_CHAN_InBus;
                if (32'({1'b0, rx_byte[6:0]}) >= MapBytes) begin
                  oob_d = 1'b1;
                  err_d = 1'b1;
                  tx_d  = 8'h00;
                end else begin
                  tx_d = byte_of(SPI_TELEM_CHAN_InBus, {1'b0, rx_byte[6:0]});
                end
              end else begin
                state_d = StWr;
                tx_d    = 8'h00;
              end
            end else if (state_q == StRd) begin
              addr_d = next_addr;
              tx_d   = oob_q ? 8'h00 : byte_of(shadow_q, next_addr);
            end else begin
              seen_d = 1'b1;
              if (32'(addr_q) >= NUM_CTRL) begin
                err_d = 1'b1;
              end
              for (int unsigned r = 0; r < NUM_CTRL; r++) begin
                if (32'(addr_q) == r) begin
                  pend_d[r*8 +: 8] = rx_byte;
                end
              end
              // Saturate rather than wrap so late bytes can never alias register 0.
              if (addr_q != 8'hFF) begin
                addr_d = addr_q + 8'd1;
              end
            end
          end
        end
      end
      StEnd: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign SPI_TELEM_MISO_Out = (!ss && (state_q == StCmd || state_q == StRd || state_q == StWr))
                              ? miso_q : 1'b0;
  assign SPI_TELEM_CTRL_OutBus    = ctrl_q;
  assign SPI_TELEM_CTRLUPDATE_Out = upd_q;
  assign SPI_TELEM_FRAMEERR_Out   = ferr_q;
  assign SPI_TELEM_BUSY_Out       = !ss && (state_q != StIdle);

endmodule

// File: tb/tb_spi_telemetry_slave.sv
// Scoreboard bench for spi_telemetry_slave: a host model drives frames, a byte-map reference
// predicts MISO bytes and control commits, and monitors compare them as they appear.
module tb_spi_telemetry_slave;

  localparam int NCH   = 16;
  localparam int WB    = 4;
  localparam int NCTRL = 4;
  localparam int MAPB  = NCH * WB;
  localparam int HALF  = 10;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   ss_n = 1'b1;
  logic                   sck = 1'b0;
  logic                   mosi = 1'b0;
  logic [NCH*WB*8-1:0]    chan = '0;
  logic                   miso;
  logic [NCTRL*8-1:0]     ctrl;
  logic                   upd, ferr, busy;

  always #10 clk = ~clk;

  spi_telemetry_slave #(
    .NUM_CHANNELS(NCH),
    .WORD_BYTES  (WB),
    .NUM_CTRL    (NCTRL),
    .STATUS_ID   (8'hA5)
  ) dut (
    .SPI_TELEM_CLOCK_50      (clk),
    .SPI_TELEM_RESET_InLow   (rst_n),
    .SPI_TELEM_SS_InLow      (ss_n),
    .SPI_TELEM_SCK_In        (sck),
    .SPI_TELEM_MOSI_In       (mosi),
    .SPI_TELEM_CHAN_InBus    (chan),
    .SPI_TELEM_MISO_Out      (miso),
    .SPI_TELEM_CTRL_OutBus   (ctrl),
    .SPI_TELEM_CTRLUPDATE_Out(upd),
    .SPI_TELEM_FRAMEERR_Out  (ferr),
    .SPI_TELEM_BUSY_Out      (busy)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0]         exp_q[$];
  logic [7:0]         obs_q[$];
  logic [NCTRL*8-1:0] exp_ctrl_q[$];
  logic [7:0]         host_tx[$];
  logic [7:0]         wdata[$];
  logic [7:0]         model_ctrl[NCTRL];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [NCTRL*8-1:0] ctrl_packed();
    logic [NCTRL*8-1:0] v;
    for (int r = 0; r < NCTRL; r++) v[r*8 +: 8] = model_ctrl[r];
    return v;
  endfunction

  // Reference byte map: channel b/WB, byte b%WB counted from the most significant end.
  function automatic logic [7:0] map_byte(input logic [NCH*WB*8-1:0] c, input int b);
    logic [8*WB-1:0] w;
    w = c[(b / WB) * 8 * WB +: 8 * WB];
    w = w >> (8 * (WB - 1 - (b % WB)));
    return w[7:0];
  endfunction

  task automatic randomize_chan();
    for (int k = 0; k < NCH * WB; k++) chan[k*8 +: 8] = 8'($urandom);
  endtask

  // Host side of one SPI byte (mode 0, MSB first); captures MISO at each rising SCK.
  task automatic spi_byte(input logic [7:0] d, input int nbits, output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = d[i];
      repeat (HALF) @(negedge clk);
      sck  = 1'b1;
      r[i] = miso;
      repeat (HALF) @(negedge clk);
      sck  = 1'b0;
    end
  endtask

  task automatic run_frame(input int extra_bits, input bit change_mid);
    logic [7:0] r;
    ss_n = 1'b0;
    repeat (HALF) @(negedge clk);
    check("busy_in_frame", busy, 1'b1);
    for (int n = 0; n < host_tx.size(); n++) begin
      spi_byte(host_tx[n], 8, r);
      obs_q.push_back(r);
      if (n == 0 && change_mid) randomize_chan();
    end
    if (extra_bits > 0) spi_byte(8'($urandom), extra_bits, r);
    repeat (HALF) @(negedge clk);
    ss_n = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    check("busy_after_frame", busy, 1'b0);
    check("miso_idle", miso, 1'b0);
  endtask

  task automatic read_frame(input logic [7:0] cmd, input int n, input int extra,
                            input bit change_mid);
    logic [NCH*WB*8-1:0] snap;
    int a;
    snap = chan;
    a    = int'(cmd[6:0]);
    host_tx = {};
    host_tx.push_back(cmd);
    exp_q.push_back(8'hA5);
    for (int i = 0; i < n; i++) begin
      host_tx.push_back(8'($urandom));
      exp_q.push_back((a >= MAPB) ? 8'h00 : map_byte(snap, (a + i) % MAPB));
    end
    run_frame(extra, change_mid);
    check("read_frame_err", ferr, (a >= MAPB) ? 1'b1 : 1'b0);
  endtask

  task automatic write_frame(input logic [7:0] cmd, input int extra);
    logic [7:0] pend[NCTRL];
    bit err;
    int a;
    err  = 1'b0;
    pend = model_ctrl;
    host_tx = {};
    host_tx.push_back(cmd);
    exp_q.push_back(8'hA5);
    for (int i = 0; i < wdata.size(); i++) begin
      host_tx.push_back(wdata[i]);
      exp_q.push_back(8'h00);
      a = int'(cmd[6:0]) + i;
      if (a < NCTRL) pend[a] = wdata[i];
      else err = 1'b1;
    end
    if (extra > 0) begin
      err = 1'b1;
    end else if (wdata.size() > 0) begin
      model_ctrl = pend;
      exp_ctrl_q.push_back(ctrl_packed());
    end
    run_frame(extra, 1'b0);
    check("write_frame_err", ferr, err);
    check("ctrl_bus", ctrl, ctrl_packed());
  endtask

  // MISO byte monitor.
  initial begin
    logic [7:0] r;
    forever begin
      @(posedge clk);
      while (obs_q.size() > 0) begin
        r = obs_q.pop_front();
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL miso_byte_unexpected actual=%0h required=none", r);
        end else begin
          check("miso_byte", r, exp_q.pop_front());
        end
      end
    end
  end

  // Control-commit monitor; a pulse longer than one clock finds an empty queue.
  initial begin
    forever begin
      @(negedge clk);
      if (upd === 1'b1) begin
        if (exp_ctrl_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ctrl_update_unexpected actual=%0h required=none", ctrl);
        end else begin
          check("ctrl_commit", ctrl, exp_ctrl_q.pop_front());
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] r;
    for (int i = 0; i < NCTRL; i++) model_ctrl[i] = 8'h00;
    randomize_chan();
    repeat (5) @(negedge clk);
    check("rst_miso", miso, 1'b0);
    check("rst_ctrl", ctrl, '0);
    check("rst_upd", upd, 1'b0);
    check("rst_ferr", ferr, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    chan[31:0] = 32'h11223344;
    read_frame(8'h80, 4, 0, 1'b0);

    chan[15*32 +: 32] = 32'hDEADBEEF;
    chan[31:0]        = 32'h01020304;
    read_frame(8'hBC, 6, 0, 1'b0);

    read_frame(8'h80 | 8'($urandom_range(0, 63)), 5, 0, 1'b1);

    wdata = '{8'h7F, 8'h80};
    write_frame(8'h01, 0);

    wdata = '{8'h55};
    write_frame(8'h02, 3);
    read_frame(8'h84, 2, 0, 1'b0);

    wdata = '{8'hAA, 8'hBB};
    write_frame(8'h03, 0);

    wdata = {};
    write_frame(8'h00, 0);

    read_frame(8'hC5, 2, 0, 1'b0);
    read_frame(8'h90, 3, 5, 1'b0);

    for (int t = 0; t < 18; t++) begin
      randomize_chan();
      if ($urandom_range(0, 1) == 1) begin
        read_frame(8'h80 | 8'($urandom_range(0, 127)), $urandom_range(0, 6),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0,
                   $urandom_range(0, 1) == 1);
      end else begin
        wdata = {};
        for (int i = $urandom_range(0, 5); i > 0; i--) wdata.push_back(8'($urandom));
        write_frame(8'($urandom_range(0, 5)),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0);
      end
    end

    // Asynchronous reset in the middle of a write data byte.
    ss_n = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_byte(8'h00, 8, r);
    spi_byte(8'h12, 5, r);
    #3 rst_n = 1'b0;
    #2;
    check("midrst_ctrl", ctrl, '0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_miso", miso, 1'b0);
    check("midrst_ferr", ferr, 1'b0);
    for (int i = 0; i < NCTRL; i++) model_ctrl[i] = 8'h00;
    ss_n = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    wdata = '{8'h3C};
    write_frame(8'h02, 0);

    repeat (20) @(negedge clk);
    check("miso_queue_drained", 32'(exp_q.size()), 32'd0);
    check("ctrl_queue_drained", 32'(exp_ctrl_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_telemetry_slave.md
Name: spi_telemetry_slave

Overview:
- Parametrised successor to the robot's SPI slave and message-interpreter pair: an SPI mode-0 slave with an addressed, auto-incrementing byte register map.
- Host reads are coherent: all telemetry channels are snapshotted when a read command is decoded. Host writes update a control-register bank atomically at frame end.
- Sits between the external host (SBC/MCU) and the robot datapath (odometry, RPM, distance, IMU, behaviour).

Parameters:
NUM_CHANNELS, 16, number of telemetry channels
WORD_BYTES, 4, bytes per channel (channel width = 8*WORD_BYTES)
NUM_CTRL, 4, number of 8-bit host-writable control registers
STATUS_ID, 8'hA5, byte shifted out on MISO during the command byte

Ports:
SPI_TELEM_CLOCK_50  in  1  system clock, 50 MHz
SPI_TELEM_RESET_InLow  in  1  asynchronous active-low reset
SPI_TELEM_SS_InLow  in  1  slave select, active low
SPI_TELEM_SCK_In  in  1  SPI clock (asynchronous to system clock)
SPI_TELEM_MOSI_In  in  1  host data in
SPI_TELEM_CHAN_InBus  in  NUM_CHANNELS*WORD_BYTES*8  telemetry; channel k at [k*8*WORD_BYTES +: 8*WORD_BYTES]
SPI_TELEM_MISO_Out  out  1  slave data out
SPI_TELEM_CTRL_OutBus  out  NUM_CTRL*8  control registers; register r at [r*8 +: 8]
SPI_TELEM_CTRLUPDATE_Out  out  1  one-clock pulse when the control bank commits
SPI_TELEM_FRAMEERR_Out  out  1  sticky error flag; cleared by a good frame
SPI_TELEM_BUSY_Out  out  1  high while a frame is active

Behaviour:
- Reset values: MISO=0, CTRL=0, CTRLUPDATE=0, FRAMEERR=0, BUSY=0; FSM in IDLE. Reset is asynchronous and may assert mid-frame; the frame is abandoned and any pending writes are lost.
- SS, SCK and MOSI each pass through a 2-FF synchroniser. SCK edges are detected in the system-clock domain.
- SPI mode 0, MSB first. MOSI is sampled on the synced SCK rising edge; MISO is updated on the synced falling edge. Supported SCK <= CLOCK_50/16.
- Bit counter 0..7, reset on SS falling. A byte completes on the 8th rising edge.
- Byte 0 is the command: bit7=1 means read, bit7=0 means write; bits[6:0] = start byte address A.
- MISO shifts STATUS_ID during byte 0. MISO=0 whenever SS is high.
- FSM states:
  - IDLE -> CMD on SS falling.
  - CMD -> RD or WR on byte 0 complete.
  - RD/WR -> END on SS rising.
  - END -> IDLE after 1 clock.
  - SS rising in any state goes to END.
- Read decode:
  - On byte 0 complete, copy the whole CHAN bus into a shadow buffer in the same clock.
  - Byte index b = k*WORD_BYTES + j; j=0 is the channel's MSByte.
  - The first data byte (address A) is loaded into the MISO shifter before the next falling edge. Its MSB is driven on the 8th falling edge of byte 0.
  - Address auto-increments per byte and wraps from NUM_CHANNELS*WORD_BYTES-1 to 0.
  - If A >= NUM_CHANNELS*WORD_BYTES: data bytes read 8'h00 and the frame is flagged as an error.
- Write decode:
  - Each completed data byte is written to a pending copy of the control bank at the current address, which then auto-increments with no wrap.
  - Bytes at address >= NUM_CTRL are ignored and flag an error.
  - On SS rising with bit counter = 0 and at least one data byte received: copy pending to CTRL and pulse CTRLUPDATE for 1 clock in END.
  - On SS rising with bit counter != 0 (partial byte): discard the pending copy, no commit, error.
  - A write frame with no data bytes: no commit, no error.
- FRAMEERR is updated in END: set if the frame had an error, cleared otherwise. A read frame ending mid-byte is not an error.
- Pending bank is reloaded from CTRL at each CMD entry, so unwritten registers keep their value.
- BUSY = synced SS low, excluding the IDLE state.
- SS falling during END is taken on the next clock; no frame is lost.

Test Plan:
- Reset, then read frame cmd 0x80 with CHAN ch0=0x11223344 + 4 dummy bytes -> MISO bytes A5,11,22,33,44; FRAMEERR=0.
- Read cmd 0xBC (A=60) with NUM_CHANNELS=16, ch15=0xDEADBEEF, ch0=0x01020304, 6 data bytes -> EF... sequence: BE? No: bytes 60..63 = DE,AD,BE,EF, then wrap to 01,02.
- Change CHAN mid-read after the command byte -> streamed bytes still equal values captured at byte-0 completion.
- Write cmd 0x01, data 0x7F,0x80, SS high on byte boundary -> CTRL reg1=0x7F, reg2=0x80, others unchanged; single CTRLUPDATE pulse; FRAMEERR=0.
- Write cmd 0x02, data 0x55 then 3 bits, SS high -> CTRL unchanged, no CTRLUPDATE, FRAMEERR=1. A following good read clears FRAMEERR.
- Write cmd 0x03, data 0xAA,0xBB -> reg3=0xAA, 0xBB ignored, commit occurs, FRAMEERR=1. Separately, async reset mid-write -> all CTRL=0, FSM IDLE.
